// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int CNT_W_DEF   = 32;
  localparam int DIV_W_DEF   = 16;
  localparam int DIV_RST_DEF = 1;
  localparam int CH_SEL_W    = 3;

  // True when a load strobe targets channel idx.
  function automatic logic ch_hit(input logic load, input logic [CH_SEL_W-1:0] sel,
                                  input int unsigned idx);
    return load && (sel == CH_SEL_W'(idx));
  endfunction

endpackage

// File: rtl/multi_clkdiv_if.sv
// Control/status bundle of the multi-channel clock divider.
interface multi_clkdiv_if
  import clkdiv_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) ();

  logic                en;
  logic                clr;
  logic                load;
  logic [CH_SEL_W-1:0] ch_sel;
  logic [DIV_W-1:0]    div_val;
  logic [CNT_W-1:0]    count;
  logic [N_CH-1:0]     tick;
  logic [N_CH-1:0]     sq;

  modport master (
    output en, clr, load, ch_sel, div_val,
    input  count, tick, sq
  );

  modport slave (
    input  en, clr, load, ch_sel, div_val,
    output count, tick, sq
  );

endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: divide register, terminal counter, tick pulse and square wave.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_val_i,
  output logic             tick_o,
  output logic             sq_o
);

  logic [DIV_W-1:0] d_q, d_d;
  logic [DIV_W-1:0] c_q, c_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  // Next state: load wins over terminal count; en=0 freezes everything but tick.
  always_comb begin
    d_d    = d_q;
    c_d    = c_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    if (load_i) begin
      d_d = div_val_i;
      c_d = '0;
    end else if (en_i) begin
      // >= keeps the counter from ever running past D
      if (c_q >= d_q) begin
        c_d    = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
      end else begin
        c_d = c_q + DIV_W'(1);
      end
    end
  end

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q    <= DIV_W'(DIV_RST);
      c_q    <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      d_q    <= d_d;
      c_q    <= c_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/multi_clkdiv.sv
// Free-running counter plus N_CH independently loadable divider channels.
module multi_clkdiv
  import clkdiv_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic           clk,
  input  logic           rst,
  multi_clkdiv_if.slave  bus
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [N_CH-1:0]  tick_w;
  logic [N_CH-1:0]  sq_w;

  // Free-running counter next state: clear beats increment.
  always_comb begin
    count_d = count_q;
    if (bus.clr)
      count_d = '0;
    else if (bus.en)
      count_d = count_q + CNT_W'(1);
  end

  // Free-running counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  // Out-of-range ch_sel matches no channel, so such loads fall away.
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    clkdiv_chan #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en_i      (bus.en),
      .load_i    (ch_hit(bus.load, bus.ch_sel, i)),
      .div_val_i (bus.div_val),
      .tick_o    (tick_w[i]),
      .sq_o      (sq_w[i])
    );
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_w;
  assign bus.sq    = sq_w;

endmodule

// File: doc/multi_clkdiv.md
MULTI_CLKDIV -- requirements
Module: multi_clkdiv

Interface
REQ-001 Parameter N_CH, 4: number of independent divider channels, 1..8.
REQ-002 Parameter CNT_W, 32: width of free-running counter output.
REQ-003 Parameter DIV_W, 16: width of each channel's divide register.
REQ-004 Parameter DIV_RST, 1: divide value loaded into every channel at reset.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  global count enable; low freezes all counters.
REQ-008 clr  in  1  synchronous clear of the free-running counter only.
REQ-009 load  in  1  write strobe for one channel's divide register.
REQ-010 ch_sel  in  3  channel index for load.
REQ-011 div_val  in  DIV_W  divide value written on load.
REQ-012 count  out  CNT_W  free-running counter.
REQ-013 tick  out  N_CH  per-channel one-cycle pulse at channel terminal count.
REQ-014 sq  out  N_CH  per-channel divided square wave.

Function
REQ-015 count SHALL increment by 1 each cycle with en=1, hold with en=0, wrap from all-ones to 0.
REQ-016 clr=1 SHALL set count to 0 next cycle regardless of en; clr has priority over increment.
REQ-017 Each channel SHALL hold a DIV_W divide register D and a DIV_W counter C.
REQ-018 With en=1 and C<D, C SHALL increment by 1 and tick bit stays 0.
REQ-019 With en=1 and C==D, C SHALL return to 0, tick bit SHALL be 1 for exactly that cycle (registered, visible the following cycle), sq bit SHALL toggle.
REQ-020 Tick period SHALL be D+1 cycles; sq period SHALL be 2(D+1) cycles, 50% duty.
REQ-021 D=0 SHALL give tick high every enabled cycle and sq toggling every cycle.
REQ-022 With en=0, C, sq and D-hold SHALL freeze, and all tick bits SHALL be 0.
REQ-023 load=1 with ch_sel<N_CH SHALL write div_val to D of that channel and set its C to 0 next cycle; tick of that channel 0 next cycle; sq unchanged; other channels unaffected.
REQ-024 load SHALL act regardless of en.
REQ-025 load with ch_sel>=N_CH SHALL be ignored.
REQ-026 load to a channel in the same cycle as its terminal count SHALL take precedence: no tick, no sq toggle, C=0.
REQ-027 Lowering D below current C via load is safe by REQ-023 (C restarts at 0); no channel SHALL ever count past D.

Reset
REQ-028 rst=1 SHALL immediately set count=0, every C=0, every D=DIV_RST, tick=0, sq=0.
REQ-029 rst asserted mid-period SHALL abort it; first tick after release occurs DIV_RST+1 enabled cycles after rst deasserts.
REQ-030 All outputs SHALL be driven directly from registers.

Structure
REQ-031 Shared package clkdiv_pkg SHALL hold defaults for N_CH, CNT_W, DIV_W, DIV_RST and the ch_sel width constant.
REQ-032 One sub-module clkdiv_chan (D, C, tick, sq for a single channel) SHALL be instantiated N_CH times by generate loop.

Verification
REQ-033 Reset then en=1, 20 cycles -> count=20, each channel (D=1) ticks every 2 cycles, sq period 4.
REQ-034 load ch 2 div_val=4, en=1 -> ch2 tick every 5 cycles, sq period 10; ch0,1,3 unchanged.
REQ-035 load ch 0 div_val=0 -> tick[0] high every cycle, sq[0] toggles every cycle.
REQ-036 en=0 for 7 cycles mid-period -> count, C, sq frozen, tick=0; resumes with same phase.
REQ-037 count preset near wrap via CNT_W=4 build, 17 cycles -> count wraps 15->0; clr pulse -> count=0 next cycle.
REQ-038 rst pulse mid-period and load ch_sel=5 (N_CH=4) -> all state to reset values; invalid load changes nothing.
